tmp_decim: RTL and testbench
============================

# tmp_decim

Pump-event decimator that sits directly downstream of the temperature-sensor sequencer. It consumes the sequencer's source/sink pump-control toggles and turns the pump decisions into a ones-density code. The code is the number of source pumps in a fixed window of N pump events. It presents each window result on a valid/ack handshake to the readout logic.

## Interface
Parameters:
- WIN_LOG2, 6: window length N = 2^WIN_LOG2 pump events (legal 2..10)
- SETTLE_EVT, 8: pump events discarded after bias setup ends, before the first window (0..255)

Ports:
- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- setup_bias  in  1  sequencer bias-setup phase; 1 = hold idle
- src_tgl  in  1  sequencer source-pump control; every level change = one source event
- snk_tgl  in  1  sequencer sink-pump control; every level change = one sink event
- code  out  WIN_LOG2+1  source-event count of the last closed window (0..N)
- code_valid  out  1  code holds an unacknowledged result
- code_ack  in  1  consumer accepts code when code_valid & code_ack
- busy  out  1  1 in SETTLE or ACCUM
- overrun  out  1  sticky: a window closed while code_valid was still high

## Operation
- Edge detect: src_tgl/snk_tgl registered each cycle. src_evt = src_tgl ^ src_q, snk_evt likewise.
- Edge-detect registers load the current input levels during reset, so no spurious event occurs after reset release.
- FSM states: IDLE, SETTLE, ACCUM, DUMP.
- IDLE: counters cleared. Moves on the first cycle with setup_bias==0: to SETTLE if SETTLE_EVT>0, else to ACCUM.
- SETTLE: settle_cnt += src_evt+snk_evt. Moves to ACCUM on the cycle the count reaches ≥SETTLE_EVT. The events of that cycle are discarded.
- ACCUM: evt_cnt += src_evt+snk_evt (0, 1 or 2 per cycle), src_cnt += src_evt.
- ACCUM closes when the next evt_cnt ≥ N. On the closing cycle, a simultaneous snk_evt that would make the count N+1 is dropped; src_evt is always counted.
- src_cnt saturates at N.
- ACCUM goes to DUMP after the closing cycle.
- DUMP (1 cycle): code <= src_cnt and code_valid <= 1. If code_valid was already 1 and code_ack is 0 this cycle, set overrun and overwrite code. Clear evt_cnt and src_cnt, return to ACCUM.
- Events arriving during DUMP are counted into the new window.
- Handshake: code_valid drops the cycle after code_valid & code_ack. An ack in the same cycle as DUMP is a completed handshake on the old code: no overrun, and code_valid stays 1 with the new code.
- setup_bias rising in SETTLE/ACCUM/DUMP aborts the current window, with no output, next cycle → IDLE. code, code_valid and overrun are retained.
- overrun clears only on reset.

## Timing
- Reset values: code=0, code_valid=0, busy=0, overrun=0, state=IDLE, all counters 0.
- An input toggle at edge k produces an event counted at edge k+1.
- The closing event counted at edge k+1 puts the FSM in DUMP; code and code_valid update at edge k+2. Toggle to code_valid = 2 cycles.
- busy is 1 in SETTLE and ACCUM, and 0 in IDLE and DUMP. It is registered from the next state, so it changes together with the state transition.
- Reset low during any state: all outputs take reset values at the next edge, and the pending window is discarded.
- Counter widths: evt_cnt/src_cnt WIN_LOG2+1 bits, settle_cnt 8 bits. No wrap is reachable.

## Configuration
- TMP_DECIM_AVG_EN defined: an averaging stage sits between DUMP and the output.
  - code = (current window + previous window + 1) >> 1, truncated to WIN_LOG2+1 bits.
  - The first window after leaving IDLE uses its own value as "previous".
  - The previous-window register clears on reset and on entering IDLE.
  - Latency is unchanged: combinational add in DUMP.
- Not defined: code = raw src_cnt of the window, and the averaging register is not present.

## Test plan
- Reset/idle: reset=0 for 3 cycles while inputs toggle, then setup_bias=1 → code=0, code_valid=0, busy=0, no events counted.
- Basic window (WIN_LOG2=6, SETTLE_EVT=8): drop setup_bias, issue 8 settle toggles, then 64 events alternating src/snk → code=32, code_valid=1 two cycles after the 64th toggle. Ack → code_valid=0 next cycle.
- Extremes: window of 64 src-only events → code=64. Window of 64 snk-only events → code=0.
- Simultaneous events: 63 events, then src and snk toggling in the same cycle → window closes, snk dropped, code = prior src count + 1. Next window starts at evt_cnt=0.
- Overrun: two windows with no ack → overrun=1, code equals the second result. Repeat with ack asserted exactly in the DUMP cycle → overrun stays 0.
- Abort/AVG: raise setup_bias mid-ACCUM → IDLE, no code_valid, overrun unchanged. With TMP_DECIM_AVG_EN, windows of 40 then 21 src events → codes 40 then 31.

Source files
------------

// File: rtl/tmp_decim.sv
`default_nettype none
// ============================================================================
//  Module      : tmp_decim
//  Description : Pump-event decimator for the temperature-sensor sequencer.
//                Counts source pumps over a fixed window of N = 2^WIN_LOG2
//                pump events (source + sink toggles). Each window result is
//                presented as a ones-density code on a valid/ack handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIN_LOG2    window length N = 2^WIN_LOG2 pump events (2..10)
//    SETTLE_EVT  pump events discarded after bias setup, before first window
//  Ports
//    clk         rising-edge clock
//    reset       synchronous active-low reset (0 = reset)
//    setup_bias  1 = hold idle / abort the current window
//    src_tgl     source-pump toggle; each level change is one source event
//    snk_tgl     sink-pump toggle; each level change is one sink event
//    code        source count of the last closed window (0..N)
//    code_valid  code holds an unacknowledged result
//    code_ack    consumer accepts code when code_valid & code_ack
//    busy        1 while settling or accumulating
//    overrun     sticky: a window closed while code_valid was still high
//  Build option
//    TMP_DECIM_AVG_EN  when defined, code is the rounded mean of the current
//                      and previous window counts
// ============================================================================
module tmp_decim #(
    parameter int WIN_LOG2   = 6,
    parameter int SETTLE_EVT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                setup_bias,
    input  logic                src_tgl,
    input  logic                snk_tgl,
    output logic [WIN_LOG2:0]   code,
    output logic                code_valid,
    input  logic                code_ack,
    output logic                busy,
    output logic                overrun
);

    localparam int              CW            = WIN_LOG2 + 1;
    localparam logic [CW-1:0]   c_win_n       = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [8:0]      c_settle_evt  = 9'(SETTLE_EVT);
    localparam bit              c_settle_en   = (SETTLE_EVT > 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_ACCUM  = 2'd2,
        S_DUMP   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_src_q;
    logic            r_snk_q;
    logic [CW-1:0]   r_evt_cnt;
    logic [CW-1:0]   r_src_cnt;
    logic [7:0]      r_settle_cnt;

    logic            w_src_evt;
    logic            w_snk_evt;
    logic [1:0]      w_evt_inc;
    logic [CW-1:0]   w_evt_nxt;
    logic            w_close;
    logic [CW-1:0]   w_src_nxt;
    logic [8:0]      w_settle_nxt;
    logic [CW-1:0]   w_dump_code;

    assign w_src_evt    = src_tgl ^ r_src_q;
    assign w_snk_evt    = snk_tgl ^ r_snk_q;
    assign w_evt_inc    = {1'b0, w_src_evt} + {1'b0, w_snk_evt};
    assign w_evt_nxt    = r_evt_cnt + CW'(w_evt_inc);
    // A sink event that would push the count to N+1 on the closing cycle is
    // simply never looked at again: the event count is cleared in DUMP.
    assign w_close      = (w_evt_nxt >= c_win_n);
    assign w_src_nxt    = (r_src_cnt >= c_win_n) ? c_win_n
                                                 : r_src_cnt + CW'(w_src_evt);
    assign w_settle_nxt = {1'b0, r_settle_cnt} + {7'b0, w_evt_inc};

`ifdef TMP_DECIM_AVG_EN
    logic [CW-1:0]   r_prev;
    logic            r_prev_vld;
    logic [CW:0]     w_avg_sum;

    // First window after IDLE averages with itself, i.e. passes through.
    assign w_avg_sum   = {1'b0, r_src_cnt}
                       + {1'b0, (r_prev_vld ? r_prev : r_src_cnt)}
                       + {{CW{1'b0}}, 1'b1};
    assign w_dump_code = CW'(w_avg_sum >> 1);

    always_ff @(posedge clk) begin
        if (!reset || r_state == S_IDLE) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
        end else if (r_state == S_DUMP && !setup_bias) begin
            r_prev     <= r_src_cnt;
            r_prev_vld <= 1'b1;
        end
    end
`else
    assign w_dump_code = r_src_cnt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (!setup_bias)
                          w_state_nxt = c_settle_en ? S_SETTLE : S_ACCUM;
            S_SETTLE: if (setup_bias)                        w_state_nxt = S_IDLE;
                      else if (w_settle_nxt >= c_settle_evt) w_state_nxt = S_ACCUM;
            S_ACCUM:  if (setup_bias)                        w_state_nxt = S_IDLE;
                      else if (w_close)                      w_state_nxt = S_DUMP;
            S_DUMP:   w_state_nxt = setup_bias ? S_IDLE : S_ACCUM;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            // Track input levels so release from reset sees no phantom edge.
            r_src_q      <= src_tgl;
            r_snk_q      <= snk_tgl;
            r_evt_cnt    <= '0;
            r_src_cnt    <= '0;
            r_settle_cnt <= '0;
            code         <= '0;
            code_valid   <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            r_src_q <= src_tgl;
            r_snk_q <= snk_tgl;
            r_state <= w_state_nxt;
            busy    <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_ACCUM);

            if (code_valid && code_ack)
                code_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_evt_cnt    <= '0;
                    r_src_cnt    <= '0;
                    r_settle_cnt <= '0;
                end
                S_SETTLE: begin
                    r_settle_cnt <= w_settle_nxt[7:0];
                end
                S_ACCUM: begin
                    r_evt_cnt <= w_evt_nxt;
                    r_src_cnt <= w_src_nxt;
                end
                S_DUMP: begin
                    if (!setup_bias) begin
                        // Ack in this same cycle retires the old code, so
                        // only an unacked pending result counts as overrun.
                        code       <= w_dump_code;
                        code_valid <= 1'b1;
                        if (code_valid && !code_ack)
                            overrun <= 1'b1;
                    end
                    // Events seen during DUMP open the next window.
                    r_evt_cnt <= CW'(w_evt_inc);
                    r_src_cnt <= CW'(w_src_evt);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tmp_decim.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tmp_decim
//  Description : Self-checking bench for tmp_decim. A window-level model of
//                the decimator is compared with the DUT every cycle, and
//                hand-computed codes pin the model at key points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tmp_decim;

    localparam int WL = 6;
    localparam int SE = 8;
    localparam int N  = 1 << WL;

    localparam int P_IDLE   = 0;
    localparam int P_SETTLE = 1;
    localparam int P_ACCUM  = 2;
    localparam int P_DUMP   = 3;

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic          setup_bias = 1'b1;
    logic          src_tgl    = 1'b0;
    logic          snk_tgl    = 1'b0;
    logic          code_ack   = 1'b0;
    logic [WL:0]   code;
    logic          code_valid;
    logic          busy;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tmp_decim #(.WIN_LOG2(WL), .SETTLE_EVT(SE)) dut (
        .clk        (clk),
        .reset      (reset),
        .setup_bias (setup_bias),
        .src_tgl    (src_tgl),
        .snk_tgl    (snk_tgl),
        .code       (code),
        .code_valid (code_valid),
        .code_ack   (code_ack),
        .busy       (busy),
        .overrun    (overrun)
    );

    // ---------------- window-level reference model ----------------
    bit m_init   = 0;
    int phase    = P_IDLE;
    bit m_ps, m_pk;
    int settled, win_evts, win_srcs;
    int prev_win;
    bit has_prev;
    int m_code, m_valid, m_busy, m_ovr;

    task automatic model_step();
        bit se, ke, accepted, dumped;
        int res;
        if (!reset) begin
            m_code = 0; m_valid = 0; m_busy = 0; m_ovr = 0;
            phase = P_IDLE; has_prev = 0;
            m_ps = src_tgl; m_pk = snk_tgl;
            m_init = 1;
            return;
        end
        se = (src_tgl != m_ps);
        ke = (snk_tgl != m_pk);
        m_ps = src_tgl;
        m_pk = snk_tgl;
        accepted = (m_valid != 0) && code_ack;
        dumped = 0;
        if (phase != P_IDLE && setup_bias) begin
            phase = P_IDLE;
        end else begin
            case (phase)
                P_IDLE: begin
                    has_prev = 0; win_evts = 0; win_srcs = 0; settled = 0;
                    if (!setup_bias) phase = (SE > 0) ? P_SETTLE : P_ACCUM;
                end
                P_SETTLE: begin
                    settled += se + ke;
                    if (settled >= SE) phase = P_ACCUM;
                end
                P_ACCUM: begin
                    if (win_evts + se + ke >= N) begin
                        win_srcs = win_srcs + se;
                        if (win_srcs > N) win_srcs = N;
                        phase = P_DUMP;
                    end else begin
                        win_evts += se + ke;
                        win_srcs += se;
                    end
                end
                default: begin
                    res = win_srcs;
`ifdef TMP_DECIM_AVG_EN
                    if (has_prev) res = (win_srcs + prev_win + 1) / 2;
                    prev_win = win_srcs;
                    has_prev = 1;
`endif
                    if (m_valid != 0 && !code_ack) m_ovr = 1;
                    m_code = res;
                    m_valid = 1;
                    dumped = 1;
                    win_evts = se + ke;
                    win_srcs = se;
                    phase = P_ACCUM;
                end
            endcase
        end
        if (!dumped && accepted) m_valid = 0;
        m_busy = (phase == P_SETTLE || phase == P_ACCUM) ? 1 : 0;
    endtask

    always @(posedge clk) model_step();

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            chk("code",       32'(code),       m_code);
            chk("code_valid", 32'(code_valid), m_valid);
            chk("busy",       32'(busy),       m_busy);
            chk("overrun",    32'(overrun),    m_ovr);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input bit fs, input bit fk);
        if (fs) src_tgl = ~src_tgl;
        if (fk) snk_tgl = ~snk_tgl;
        tick();
    endtask

    task automatic win(input int ns, input int nk);
        repeat (ns) ev(1'b1, 1'b0);
        repeat (nk) ev(1'b0, 1'b1);
    endtask

    task automatic ack();
        code_ack = 1'b1;
        tick();
        code_ack = 1'b0;
    endtask

    initial begin
        // Reset held while inputs toggle.
        setup_bias = 1'b0;
        repeat (3) ev(1'b1, 1'b1);
        reset = 1'b1;
        setup_bias = 1'b1;
        ev(1'b1, 1'b0);
        ev(1'b0, 1'b1);
        tick();
        chk("idle_code",  32'(code),       0);
        chk("idle_valid", 32'(code_valid), 0);
        chk("idle_busy",  32'(busy),       0);

        // Basic alternating window after settling.
        setup_bias = 1'b0;
        tick();
        chk("settle_busy", 32'(busy), 1);
        win(SE, 0);
        repeat (N / 2) begin
            ev(1'b1, 1'b0);
            ev(1'b0, 1'b1);
        end
        chk("latency_valid_low", 32'(code_valid), 0);
        tick();
        chk("basic_code",  32'(code),       32);
        chk("basic_valid", 32'(code_valid), 1);
        ack();
        chk("ack_valid", 32'(code_valid), 0);

        // Extremes.
        win(N, 0);
        tick();
        chk("all_src_code", 32'(code), 64);
        ack();
        win(0, N);
        tick();
        chk("all_snk_code", 32'(code), 0);
        ack();

        // 63 events then a simultaneous src+snk close.
        repeat (31) begin
            ev(1'b1, 1'b0);
            ev(1'b0, 1'b1);
        end
        ev(1'b1, 1'b0);
        ev(1'b1, 1'b1);
        tick();
        chk("simul_code", 32'(code), 33);
        ack();
        win(N, 0);
        tick();
        chk("after_simul_code", 32'(code), 64);
        ack();

        // Ack exactly in the DUMP cycle: no overrun.
        win(10, 54);
        tick();
        win(20, 44);
        code_ack = 1'b1;
        tick();
        code_ack = 1'b0;
        chk("dumpack_code",    32'(code),       20);
        chk("dumpack_valid",   32'(code_valid), 1);
        chk("dumpack_overrun", 32'(overrun),    0);
        ack();

        // Two windows without ack.
        win(5, 59);
        tick();
        win(7, 57);
        tick();
        chk("ovr_flag", 32'(overrun), 1);
        chk("ovr_code", 32'(code),    7);

        // Abort mid-window.
        win(10, 10);
        setup_bias = 1'b1;
        tick();
        tick();
        chk("abort_busy",  32'(busy),       0);
        chk("abort_valid", 32'(code_valid), 1);
        chk("abort_code",  32'(code),       7);
        chk("abort_ovr",   32'(overrun),    1);
        ack();

        // Restart: partial window must be discarded.
        setup_bias = 1'b0;
        tick();
        win(SE, 0);
        win(40, 24);
        tick();
        chk("win40_code", 32'(code), 40);
        ack();
        win(21, 43);
        tick();
`ifdef TMP_DECIM_AVG_EN
        chk("win21_code", 32'(code), 31);
`else
        chk("win21_code", 32'(code), 21);
`endif
        ack();

        // Reset in the middle of a window.
        win(30, 0);
        reset = 1'b0;
        tick();
        chk("rst_code",  32'(code),       0);
        chk("rst_valid", 32'(code_valid), 0);
        chk("rst_busy",  32'(busy),       0);
        chk("rst_ovr",   32'(overrun),    0);
        reset = 1'b1;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
